// File: rtl/cpu_ctrl_hs.sv
// rtl/cpu_ctrl_hs.sv - tinycpu control FSM with req/rdy memory handshake, watchdog and debug halt/step
module cpu_ctrl_hs #(
  parameter int DW      = 8,
  parameter int TMO_CYC = 15,
  parameter bit AUTORUN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          step,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rdy,
  input  logic [1:0]    cmp,
  output logic          mem_req,
  output logic          mem_we,
  output logic          den,
  output logic          addr_ctrl,
  output logic [2:0]    mux_rA,
  output logic          rA_we,
  output logic          rB_we,
  output logic          rM_we,
  output logic          mux_rB,
  output logic [1:0]    mux_rM,
  output logic [1:0]    alu_ctrl,
  output logic          rP_inc,
  output logic          rP_load,
  output logic [DW-5:0] imm,
  output logic          halted,
  output logic          err_tmo,
  output logic          err_ill
);

  localparam int WW = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;
  localparam logic [WW-1:0] WD_LAST = WW'((TMO_CYC > 0) ? TMO_CYC - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_MEMRD, S_MEMWR, S_HALT
  } state_t;

  state_t        state;
  logic [DW-1:0] inst;
  logic          step_pending;
  logic [WW-1:0] wdog;
  logic [3:0]    op;
  logic          req_st;
  logic          tmo_hit;
  logic          jump_taken;

  assign op       = inst[DW-1:DW-4];
  assign alu_ctrl = inst[DW-3:DW-4];
  assign imm      = inst[DW-5:0];
  assign halted   = (state == S_HALT);
  assign req_st   = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  // The count reaching TMO_CYC is this cycle's increment, so compare against TMO_CYC-1
  assign tmo_hit  = (TMO_CYC != 0) && req_st && !mem_rdy && (wdog == WD_LAST);

  always_comb begin
    case (op)
      4'hC:    jump_taken = 1'b1;
      4'hD:    jump_taken = (cmp == 2'b00);
      4'hE:    jump_taken = (cmp == 2'b01);
      4'hF:    jump_taken = (cmp == 2'b10);
      default: jump_taken = 1'b0;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    den       = 1'b0;
    addr_ctrl = 1'b0;
    mux_rA    = 3'd0;
    rA_we     = 1'b0;
    rB_we     = 1'b0;
    rM_we     = 1'b0;
    mux_rB    = 1'b0;
    mux_rM    = 2'd3;
    rP_inc    = 1'b0;
    rP_load   = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        rP_inc  = mem_rdy;
      end
      S_EXEC: begin
        case (op)
          4'h0, 4'h1, 4'h2, 4'h3: begin mux_rA = 3'd1; rA_we = 1'b1; end
          4'h4: rA_we = 1'b1;
          4'hA: begin mux_rA = 3'd3; rA_we = 1'b1; end
          4'h8: begin rA_we = 1'b1; rB_we = 1'b1; mux_rA = 3'd2; end
          4'h9: begin rB_we = 1'b1; rM_we = 1'b1; mux_rB = 1'b1; mux_rM = 2'd1; end
          4'hB: begin rM_we = 1'b1; mux_rM = 2'd0; end
          4'hC, 4'hD, 4'hE, 4'hF: begin
            if (jump_taken) begin
              rP_load = 1'b1;
              rM_we   = 1'b1;
              mux_rM  = 2'd2;
            end
          end
          default: ;
        endcase
      end
      S_MEMRD: begin
        mem_req   = 1'b1;
        addr_ctrl = 1'b1;
        mux_rA    = 3'd4;
        rA_we     = mem_rdy;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        den       = 1'b1;
        addr_ctrl = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= AUTORUN ? S_IDLE : S_HALT;
      inst         <= '0;
      step_pending <= 1'b0;
      wdog         <= '0;
      err_tmo      <= 1'b0;
      err_ill      <= 1'b0;
    end else begin
      if (req_st && !mem_rdy) begin
        if (wdog != '1) wdog <= wdog + 1'b1;
      end else begin
        wdog <= '0;
      end
      case (state)
        S_IDLE: begin
          if (step_pending) begin
            step_pending <= 1'b0;
            state        <= S_HALT;
          end else begin
            state <= run ? S_FETCH : S_HALT;
          end
        end
        S_FETCH: begin
          if (mem_rdy) begin
            inst  <= mem_rdata;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (op == 4'h7) err_ill <= 1'b1;
          if (op == 4'h5)      state <= S_MEMRD;
          else if (op == 4'h6) state <= S_MEMWR;
          else                 state <= S_IDLE;
        end
        S_MEMRD, S_MEMWR: begin
          if (mem_rdy) state <= S_IDLE;
        end
        S_HALT: begin
          if (run) begin
            state <= S_IDLE;
          end else if (step) begin
            step_pending <= 1'b1;
            state        <= S_FETCH;
          end
        end
        default: state <= S_HALT;
      endcase
      // Abandoned access: no writes were issued this cycle since mem_rdy is low
      if (tmo_hit) begin
        err_tmo      <= 1'b1;
        state        <= S_HALT;
        step_pending <= 1'b0;
        wdog         <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_hs.sv
// tb/tb_cpu_ctrl_hs.sv - scoreboard bench for cpu_ctrl_hs
module tb_cpu_ctrl_hs;

  logic       clk, rst, run, step;
  logic [7:0] mem_rdata;
  logic       mem_rdy;
  logic [1:0] cmp;
  logic       mem_req, mem_we, den, addr_ctrl;
  logic [2:0] mux_rA;
  logic       rA_we, rB_we, rM_we, mux_rB;
  logic [1:0] mux_rM, alu_ctrl;
  logic       rP_inc, rP_load;
  logic [3:0] imm;
  logic       halted, err_tmo, err_ill;

  cpu_ctrl_hs #(.DW(8), .TMO_CYC(15), .AUTORUN(1'b1)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .cmp(cmp),
    .mem_req(mem_req), .mem_we(mem_we), .den(den), .addr_ctrl(addr_ctrl),
    .mux_rA(mux_rA), .rA_we(rA_we), .rB_we(rB_we), .rM_we(rM_we),
    .mux_rB(mux_rB), .mux_rM(mux_rM), .alu_ctrl(alu_ctrl),
    .rP_inc(rP_inc), .rP_load(rP_load), .imm(imm),
    .halted(halted), .err_tmo(err_tmo), .err_ill(err_ill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [7:0]  prog[$];
  logic [20:0] exp_q[$];
  int lat = 0;
  bit hang_wr = 0;
  int rcnt = 0;
  bit exec_next = 0;
  int n_exec = 0, n_rpinc = 0, n_rpload = 0, n_fetch = 0;
  int n_memrd = 0, n_memrd_we = 0, n_ra_bad = 0, n_memwr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [20:0] pk(input logic req, we, dn, ac, input logic [2:0] mra,
                                     input logic awe, bwe, mwe, mrb, input logic [1:0] mrm,
                                     input logic pinc, pld, input logic [1:0] alu, input logic [3:0] im);
    return {req, we, dn, ac, mra, awe, bwe, mwe, mrb, mrm, pinc, pld, alu, im};
  endfunction

  function automatic logic [20:0] ctrl_vec();
    return pk(mem_req, mem_we, den, addr_ctrl, mux_rA, rA_we, rB_we, rM_we,
              mux_rB, mux_rM, rP_inc, rP_load, alu_ctrl, imm);
  endfunction

  function automatic logic [20:0] exp_exec(input logic [7:0] w, input logic [1:0] c);
    logic [2:0] mra;
    logic awe, bwe, mwe, mrb, pld, tk;
    logic [1:0] mrm;
    logic [3:0] o;
    mra = 3'd0; awe = 0; bwe = 0; mwe = 0; mrb = 0; pld = 0; mrm = 2'd3;
    o = w[7:4];
    tk = (o == 4'hC) || (o == 4'hD && c == 2'b00) || (o == 4'hE && c == 2'b01) || (o == 4'hF && c == 2'b10);
    case (o)
      4'h0, 4'h1, 4'h2, 4'h3: begin mra = 3'd1; awe = 1; end
      4'h4: awe = 1;
      4'hA: begin mra = 3'd3; awe = 1; end
      4'h8: begin mra = 3'd2; awe = 1; bwe = 1; end
      4'h9: begin bwe = 1; mwe = 1; mrb = 1; mrm = 2'd1; end
      4'hB: begin mwe = 1; mrm = 2'd0; end
      4'hC, 4'hD, 4'hE, 4'hF: if (tk) begin pld = 1; mwe = 1; mrm = 2'd2; end
      default: ;
    endcase
    return pk(0, 0, 0, 0, mra, awe, bwe, mwe, mrb, mrm, 0, pld, w[5:4], w[3:0]);
  endfunction

  // One clock: memory model responds just after the edge, monitor samples on the falling edge
  task automatic cyc();
    logic [7:0] word;
    @(posedge clk);
    #1;
    if (!mem_req) begin
      mem_rdy = 0;
      rcnt = 0;
    end else begin
      mem_rdy = (mem_we && hang_wr) ? 1'b0 : (rcnt >= lat);
      if (mem_rdy) begin
        rcnt = 0;
        if (!addr_ctrl) begin
          word = (prog.size() != 0) ? prog.pop_front() : 8'h20;
          mem_rdata = word;
          exp_q.push_back(exp_exec(word, cmp));
        end
      end else begin
        rcnt++;
      end
    end
    @(negedge clk);
    if (exec_next) begin
      if (exp_q.size() == 0) chk("sb_underflow", exp_q.size(), 1);
      else begin
        chk("exec_ctrl", ctrl_vec(), exp_q.pop_front());
        n_exec++;
      end
    end
    exec_next = rst && mem_req && mem_rdy && !addr_ctrl;
    if (rP_inc) n_rpinc++;
    if (rP_load) n_rpload++;
    if (mem_req && !addr_ctrl) n_fetch++;
    if (mem_req && addr_ctrl && !mem_we) begin
      n_memrd++;
      if (rA_we) n_memrd_we++;
      if (rA_we && !mem_rdy) n_ra_bad++;
    end
    if (mem_req && mem_we) n_memwr++;
  endtask

  task automatic run_prog(input int n);
    int tgt, k;
    tgt = n_exec + n;
    run = 1;
    k = 0;
    while (n_exec < tgt && k < 200) begin cyc(); k++; end
    chk("run_done", n_exec, tgt);
    run = 0;
    k = 0;
    while (!halted && k < 60) begin cyc(); k++; end
    chk("halt_after_run", halted, 1);
  endtask

  task automatic step_one();
    int k;
    step = 1;
    cyc();
    step = 0;
    k = 0;
    while (!halted && k < 30) begin cyc(); k++; end
    chk("step_halt", halted, 1);
  endtask

  int s_exec, s_rpinc, s_rpload, s_fetch, s_memrd, s_memrd_we, s_ra_bad, s_memwr;

  task automatic snap();
    s_exec = n_exec; s_rpinc = n_rpinc; s_rpload = n_rpload; s_fetch = n_fetch;
    s_memrd = n_memrd; s_memrd_we = n_memrd_we; s_ra_bad = n_ra_bad; s_memwr = n_memwr;
  endtask

  initial begin
    int k;
    rst = 0; run = 0; step = 0; cmp = 2'b00; mem_rdata = 0; mem_rdy = 0;
    cyc(); cyc();
    chk("rst_ctrl", ctrl_vec(), pk(0,0,0,0,3'd0,0,0,0,0,2'd3,0,0,2'd0,4'd0));
    chk("rst_halted", halted, 0);
    chk("rst_err_tmo", err_tmo, 0);
    chk("rst_err_ill", err_ill, 0);
    rst = 1;
    cyc();
    chk("idle_to_halt", halted, 1);

    // LDI 7 with zero-wait memory
    snap();
    lat = 0;
    prog.push_back(8'h47);
    run_prog(1);
    chk("ldi_rpinc", n_rpinc - s_rpinc, 1);
    chk("ldi_fetch_len", n_fetch - s_fetch, 1);

    // LDM with three wait states on both fetch and data read
    snap();
    lat = 3;
    prog.push_back(8'h50);
    run_prog(1);
    chk("ldm_fetch_len", n_fetch - s_fetch, 4);
    chk("ldm_memrd_len", n_memrd - s_memrd, 4);
    chk("ldm_ra_we_cnt", n_memrd_we - s_memrd_we, 1);
    chk("ldm_ra_we_early", n_ra_bad - s_ra_bad, 0);
    chk("ldm_err_tmo", err_tmo, 0);

    // Conditional jump not taken then taken
    snap();
    lat = 0;
    cmp = 2'b01;
    prog.push_back(8'hD0);
    run_prog(1);
    chk("je_nt_rpload", n_rpload - s_rpload, 0);
    snap();
    cmp = 2'b00;
    prog.push_back(8'hD3);
    run_prog(1);
    chk("je_t_rpload", n_rpload - s_rpload, 1);

    // Mixed program with cmp = GT, one wait state
    snap();
    lat = 1;
    cmp = 2'b10;
    foreach (prog[i]) ;
    prog.push_back(8'h3A); prog.push_back(8'h15); prog.push_back(8'h2F); prog.push_back(8'h0C);
    prog.push_back(8'h8B); prog.push_back(8'h96); prog.push_back(8'hA1); prog.push_back(8'hB2);
    prog.push_back(8'hC4); prog.push_back(8'hE5); prog.push_back(8'hF6); prog.push_back(8'h4F);
    run_prog(12);
    chk("mix_rpload", n_rpload - s_rpload, 2);
    chk("mix_rpinc", n_rpinc - s_rpinc, 12);

    // Single step from HALT, twice; second is the illegal opcode
    snap();
    lat = 0;
    cmp = 2'b00;
    prog.push_back(8'h31);
    step_one();
    chk("step1_exec", n_exec - s_exec, 1);
    chk("step1_rpinc", n_rpinc - s_rpinc, 1);
    chk("step1_err_ill", err_ill, 0);
    snap();
    prog.push_back(8'h70);
    step_one();
    chk("step2_exec", n_exec - s_exec, 1);
    chk("step2_rpinc", n_rpinc - s_rpinc, 1);
    chk("ill_flag", err_ill, 1);

    // STM that never completes trips the watchdog
    snap();
    hang_wr = 1;
    prog.push_back(8'h60);
    run_prog(1);
    chk("tmo_req_len", n_memwr - s_memwr, 15);
    chk("tmo_flag", err_tmo, 1);
    chk("tmo_halted", halted, 1);
    chk("tmo_ill_kept", err_ill, 1);

    // Asynchronous reset in the middle of a write access
    prog.push_back(8'h6A);
    step = 1;
    cyc();
    step = 0;
    k = 0;
    while (!mem_we && k < 20) begin cyc(); k++; end
    chk("memwr_reached", mem_we, 1);
    cyc(); cyc();
    rst = 0;
    #1;
    chk("arst_mem_req", mem_req, 0);
    chk("arst_err_tmo", err_tmo, 0);
    chk("arst_err_ill", err_ill, 0);
    chk("arst_halted", halted, 0);
    cyc();
    rst = 1;
    hang_wr = 0;
    cyc();
    chk("post_rst_halt", halted, 1);
    chk("post_rst_req", mem_req, 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
